// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - card source drawing without replacement from one 52-card deck
//
// Purpose: draws cards for the blackjack game FSM. A free-running 16-bit LFSR picks
//   a start slot; a linear probe over a 52-bit used mask finds the first undrawn card.
//   Each card comes out as a blackjack value plus rank and suit, strobed by card_valid.
//   Keeps a count of undrawn cards and reshuffles on command or when the deck runs out.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   card_req      draw request, sampled only in IDLE while card_valid is low
//   shuffle       clears the used mask; overrides everything else
//   card_valid    one-cycle strobe: card_value/card_rank/card_suit are fresh
//   card_value    1..10 (Ace = 1, 10/J/Q/K = 10)
//   card_rank     1..13, card_suit 0..3; held until the next draw
//   cards_left    undrawn cards 0..52; deck_empty when it is zero
//   busy          high while a draw is in LOAD or PROBE
//   reshuffled    one-cycle strobe whenever the deck is refilled
module card_dealer #(
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter bit          AUTO_RESHUFFLE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       card_req,
   input  logic       shuffle,
   output logic       card_valid,
   output logic [3:0] card_value,
   output logic [3:0] card_rank,
   output logic [1:0] card_suit,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       busy,
   output logic       reshuffled
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      PROBE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] lfsr;
   logic [51:0] used;
   logic [5:0]  idx;
   logic [5:0]  idx_fold;
   logic [5:0]  idx_base;
   logic [1:0]  suit_c;
   logic [3:0]  rank_c;
   logic [3:0]  value_c;
   logic        req_ok;
   logic        auto_fill;

   // A request is only honoured once the previous card strobe has dropped.
   assign req_ok    = card_req && !card_valid;
   assign auto_fill = AUTO_RESHUFFLE && req_ok && deck_empty;

   // Slot fold and card decode of the current probe index.
   always_comb begin
      idx_fold = (lfsr[5:0] >= 6'd52) ? (lfsr[5:0] - 6'd52) : lfsr[5:0];
      if (idx >= 6'd39) begin
         suit_c   = 2'd3;
         idx_base = 6'd39;
      end else if (idx >= 6'd26) begin
         suit_c   = 2'd2;
         idx_base = 6'd26;
      end else if (idx >= 6'd13) begin
         suit_c   = 2'd1;
         idx_base = 6'd13;
      end else begin
         suit_c   = 2'd0;
         idx_base = 6'd0;
      end
      rank_c  = 4'(idx - idx_base) + 4'd1;
      value_c = (rank_c >= 4'd10) ? 4'd10 : rank_c;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; shuffle overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_ok && (!deck_empty || AUTO_RESHUFFLE)) begin
               state_nxt = LOAD;
            end
         end
         LOAD:    state_nxt = PROBE;
         PROBE: begin
            if (!used[idx]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (shuffle) begin
         state_nxt = IDLE;
      end
   end

   // Outputs decoded from state and count
   always_comb begin
      busy       = (state != IDLE);
      deck_empty = (cards_left == 6'd0);
   end

   // Datapath: LFSR, used mask, count, probe index and registered card
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr       <= LFSR_SEED;
         used       <= '0;
         cards_left <= 6'd52;
         idx        <= 6'd0;
         card_valid <= 1'b0;
         card_value <= 4'd0;
         card_rank  <= 4'd0;
         card_suit  <= 2'd0;
         reshuffled <= 1'b0;
      end else begin
         lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         card_valid <= 1'b0;
         reshuffled <= 1'b0;
         if (shuffle) begin
            used       <= '0;
            cards_left <= 6'd52;
            reshuffled <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (auto_fill) begin
                     used       <= '0;
                     cards_left <= 6'd52;
                     reshuffled <= 1'b1;
                  end
               end
               LOAD: idx <= idx_fold;
               PROBE: begin
                  if (!used[idx]) begin
                     used[idx]  <= 1'b1;
                     cards_left <= cards_left - 6'd1;
                     card_rank  <= rank_c;
                     card_suit  <= suit_c;
                     card_value <= value_c;
                     card_valid <= 1'b1;
                  end else begin
                     // Linear probe with wrap from the last slot back to slot 0.
                     idx <= (idx == 6'd51) ? 6'd0 : (idx + 6'd1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - scoreboard bench for card_dealer
module tb_card_dealer;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       card_req = 1'b0;
   logic       shuffle = 1'b0;

   logic       card_valid, deck_empty, busy, reshuffled;
   logic [3:0] card_value, card_rank;
   logic [1:0] card_suit;
   logic [5:0] cards_left;

   logic       a0_valid, a0_empty, a0_busy, a0_reshuffled;
   logic [3:0] a0_value, a0_rank;
   logic [1:0] a0_suit;
   logic [5:0] a0_left;

   card_dealer #(.LFSR_SEED(SEED), .AUTO_RESHUFFLE(1'b1)) dut (
      .clk(clk), .rst(rst), .card_req(card_req), .shuffle(shuffle),
      .card_valid(card_valid), .card_value(card_value), .card_rank(card_rank),
      .card_suit(card_suit), .cards_left(cards_left), .deck_empty(deck_empty),
      .busy(busy), .reshuffled(reshuffled)
   );

   card_dealer #(.LFSR_SEED(SEED), .AUTO_RESHUFFLE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .card_req(card_req), .shuffle(shuffle),
      .card_valid(a0_valid), .card_value(a0_value), .card_rank(a0_rank),
      .card_suit(a0_suit), .cards_left(a0_left), .deck_empty(a0_empty),
      .busy(a0_busy), .reshuffled(a0_reshuffled)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] suit;
      logic [3:0] rank;
      logic [3:0] value;
      int         lat;
   } exp_t;

   exp_t        sbq[$];
   int          passed = 0;
   int          total = 0;
   logic [15:0] m_lfsr;
   bit   [51:0] m_used;
   int          m_left;
   int          valid_cnt = 0, dbl_cnt = 0, a0_valid_cnt = 0, a0_rs_cnt = 0;
   logic        prev_valid = 1'b0;
   logic [1:0]  got_suit;
   logic [3:0]  got_rank, got_value;
   int          got_lat;
   logic        rs_at_req;

   // Reference LFSR, free-running from the same seed as the DUT.
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= SEED;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   always @(negedge clk) begin
      if (card_valid) valid_cnt <= valid_cnt + 1;
      if (card_valid && prev_valid) dbl_cnt <= dbl_cnt + 1;
      if (a0_valid) a0_valid_cnt <= a0_valid_cnt + 1;
      if (a0_reshuffled) a0_rs_cnt <= a0_rs_cnt + 1;
      prev_valid <= card_valid;
   end

   function automatic int fold(input logic [15:0] l);
      int i;
      i = int'(l[5:0]);
      if (i >= 52) i = i - 52;
      return i;
   endfunction

   // Called at #1 after the edge that moves the DUT into LOAD.
   task automatic model_draw();
      exp_t e;
      int   i, k, r;
      if (m_left == 0) begin
         m_used = '0;
         m_left = 52;
      end
      i = fold(m_lfsr);
      k = 0;
      while (m_used[i] && k < 52) begin
         i = (i == 51) ? 0 : i + 1;
         k++;
      end
      m_used[i] = 1'b1;
      m_left--;
      r = i % 13 + 1;
      e.suit  = 2'(i / 13);
      e.rank  = 4'(r);
      e.value = (r >= 10) ? 4'd10 : 4'(r);
      e.lat   = 2 + k;
      sbq.push_back(e);
   endtask

   task automatic wait_card(input string tag);
      exp_t e;
      int   lat;
      lat = 0;
      while (card_valid !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sbq.pop_front();
      total++;
      if (card_valid !== 1'b1)
         $display("FAIL %s_valid: no card_valid after %0d cycles, expected at %0d", tag, lat, e.lat);
      else if ({card_suit, card_rank, card_value} !== {e.suit, e.rank, e.value})
         $display("FAIL %s_card: got suit %0d rank %0d value %0d, expected suit %0d rank %0d value %0d",
                  tag, card_suit, card_rank, card_value, e.suit, e.rank, e.value);
      else passed++;
      total++;
      if (lat != e.lat) $display("FAIL %s_latency: got %0d, expected %0d", tag, lat, e.lat);
      else passed++;
      got_suit  = card_suit;
      got_rank  = card_rank;
      got_value = card_value;
      got_lat   = lat;
      @(posedge clk); #1;
      total++;
      if (card_valid !== 1'b0) $display("FAIL %s_strobe: card_valid %b, expected 0", tag, card_valid);
      else passed++;
   endtask

   task automatic draw_one(input string tag);
      @(negedge clk);
      card_req = 1'b1;
      @(posedge clk); #1;
      card_req = 1'b0;
      rs_at_req = reshuffled;
      model_draw();
      wait_card(tag);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      card_req = 1'b0;
      shuffle = 1'b0;
      repeat (2) @(negedge clk);
      m_used = '0;
      m_left = 52;
      sbq.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({card_valid, card_value, card_rank, card_suit, busy, reshuffled, deck_empty} !== 15'd0)
         $display("FAIL reset_outputs: got valid %b value %0d rank %0d suit %0d busy %b resh %b empty %b, expected all 0",
                  card_valid, card_value, card_rank, card_suit, busy, reshuffled, deck_empty);
      else passed++;
      total++;
      if ({a0_valid, a0_value, a0_rank, a0_suit, a0_busy, a0_reshuffled, a0_empty, a0_left} !== {15'd0, 6'd52})
         $display("FAIL reset_dut0: got left %0d busy %b valid %b, expected 52 0 0", a0_left, a0_busy, a0_valid);
      else passed++;
      m_used = '0;
      m_left = 52;
      sbq.delete();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (cards_left !== 6'd52 || deck_empty !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_release: got left %0d empty %b busy %b, expected 52 0 0", cards_left, deck_empty, busy);
      else passed++;
   endtask

   task automatic test_first_draw();
      draw_one("first");
      total++;
      if (got_lat != 2) $display("FAIL first_latency_3cyc: got %0d edges after sample, expected 2", got_lat);
      else passed++;
   endtask

   task automatic test_full_deck();
      bit [51:0] seen;
      int        vcnt[11];
      int        n_seen;
      int        bad_v;
      apply_reset();
      seen = '0;
      for (int v = 0; v < 11; v++) vcnt[v] = 0;
      for (int d = 0; d < 52; d++) begin
         draw_one($sformatf("deck%0d", d));
         if (got_rank >= 4'd1 && got_rank <= 4'd13)
            seen[int'(got_suit) * 13 + int'(got_rank) - 1] = 1'b1;
         if (got_value <= 4'd10) vcnt[got_value]++;
      end
      n_seen = 0;
      for (int i = 0; i < 52; i++) if (seen[i]) n_seen++;
      total++;
      if (n_seen != 52) $display("FAIL deck_distinct: got %0d distinct cards, expected 52", n_seen);
      else passed++;
      bad_v = 0;
      for (int v = 1; v <= 10; v++)
         if (vcnt[v] != ((v == 10) ? 16 : 4)) bad_v++;
      total++;
      if (bad_v != 0 || vcnt[0] != 0) $display("FAIL deck_value_counts: got %0d wrong value bins, expected 0", bad_v);
      else passed++;
      total++;
      if (got_lat > 55) $display("FAIL last_card_latency: got %0d, expected <= 55", got_lat);
      else passed++;
      total++;
      if (cards_left !== 6'd0 || deck_empty !== 1'b1)
         $display("FAIL deck_empty: got left %0d empty %b, expected 0 1", cards_left, deck_empty);
      else passed++;
      total++;
      if (a0_left !== 6'd0 || a0_empty !== 1'b1)
         $display("FAIL deck_empty_dut0: got left %0d empty %b, expected 0 1", a0_left, a0_empty);
      else passed++;
   endtask

   task automatic test_auto_reshuffle();
      int a0v, a0r;
      a0v = a0_valid_cnt;
      a0r = a0_rs_cnt;
      draw_one("auto53");
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (rs_at_req !== 1'b1) $display("FAIL auto_reshuffled: got %b, expected 1", rs_at_req);
      else passed++;
      total++;
      if (cards_left !== 6'd51) $display("FAIL auto_left: got %0d, expected 51", cards_left);
      else passed++;
      total++;
      if (a0_valid_cnt != a0v || a0_rs_cnt != a0r)
         $display("FAIL noauto_ignored: got %0d valid %0d reshuffled pulses, expected 0 0",
                  a0_valid_cnt - a0v, a0_rs_cnt - a0r);
      else passed++;
      total++;
      if (a0_left !== 6'd0 || a0_busy !== 1'b0)
         $display("FAIL noauto_left: got left %0d busy %b, expected 0 0", a0_left, a0_busy);
      else passed++;
   endtask

   task automatic test_held_req();
      int vc;
      apply_reset();
      vc = valid_cnt;
      @(negedge clk);
      card_req = 1'b1;
      @(posedge clk); #1;
      model_draw();
      for (int n = 0; n < 3; n++) begin
         wait_card($sformatf("held%0d", n));
         if (n < 2) begin
            total++;
            if (busy !== 1'b0) $display("FAIL held_idle_gap%0d: busy %b, expected 0", n, busy);
            else passed++;
            @(posedge clk); #1;
            model_draw();
         end else begin
            card_req = 1'b0;
         end
      end
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (valid_cnt - vc != 3 || dbl_cnt != 0)
         $display("FAIL held_count: got %0d pulses %0d doubled, expected 3 0", valid_cnt - vc, dbl_cnt);
      else passed++;
      total++;
      if (cards_left !== 6'd49) $display("FAIL held_left: got %0d, expected 49", cards_left);
      else passed++;
   endtask

   task automatic test_shuffle_probe();
      int         vc;
      logic [3:0] r_hold;
      logic [1:0] s_hold;
      apply_reset();
      draw_one("pre_shuf0");
      draw_one("pre_shuf1");
      r_hold = got_rank;
      s_hold = got_suit;
      vc = valid_cnt;
      @(negedge clk);
      card_req = 1'b1;
      @(posedge clk); #1;
      card_req = 1'b0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b1) $display("FAIL shuf_in_probe: busy %b, expected 1", busy);
      else passed++;
      @(negedge clk);
      shuffle = 1'b1;
      @(posedge clk); #1;
      shuffle = 1'b0;
      m_used = '0;
      m_left = 52;
      total++;
      if (reshuffled !== 1'b1 || cards_left !== 6'd52 || busy !== 1'b0 || card_valid !== 1'b0)
         $display("FAIL shuf_probe: got resh %b left %0d busy %b valid %b, expected 1 52 0 0",
                  reshuffled, cards_left, busy, card_valid);
      else passed++;
      total++;
      if (card_rank !== r_hold || card_suit !== s_hold)
         $display("FAIL shuf_hold_card: got rank %0d suit %0d, expected %0d %0d", card_rank, card_suit, r_hold, s_hold);
      else passed++;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (valid_cnt != vc) $display("FAIL shuf_abort: got %0d card_valid pulses, expected 0", valid_cnt - vc);
      else passed++;
   endtask

   task automatic test_same_cycle();
      int vc;
      vc = valid_cnt;
      @(negedge clk);
      card_req = 1'b1;
      shuffle = 1'b1;
      @(posedge clk); #1;
      card_req = 1'b0;
      shuffle = 1'b0;
      total++;
      if (reshuffled !== 1'b1 || busy !== 1'b0)
         $display("FAIL same_cycle: got resh %b busy %b, expected 1 0", reshuffled, busy);
      else passed++;
      repeat (8) @(posedge clk);
      #1;
      total++;
      if (valid_cnt != vc || cards_left !== 6'd52)
         $display("FAIL same_cycle_nodraw: got %0d pulses left %0d, expected 0 52", valid_cnt - vc, cards_left);
      else passed++;
   endtask

   task automatic test_reset_mid_probe();
      logic [9:0] seq1[4];
      apply_reset();
      for (int d = 0; d < 4; d++) begin
         draw_one($sformatf("det_a%0d", d));
         seq1[d] = {got_suit, got_rank, got_value};
      end
      @(negedge clk);
      card_req = 1'b1;
      @(posedge clk); #1;
      card_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++;
      if ({card_valid, card_value, card_rank, card_suit, busy, reshuffled} !== 12'd0 || cards_left !== 6'd52)
         $display("FAIL rst_mid_probe: got valid %b rank %0d busy %b left %0d, expected 0 0 0 52",
                  card_valid, card_rank, busy, cards_left);
      else passed++;
      apply_reset();
      for (int d = 0; d < 4; d++) begin
         draw_one($sformatf("det_b%0d", d));
         total++;
         if ({got_suit, got_rank, got_value} !== seq1[d])
            $display("FAIL determinism%0d: got %h, expected %h", d, {got_suit, got_rank, got_value}, seq1[d]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_first_draw();
      test_full_deck();
      test_auto_reshuffle();
      test_held_req();
      test_shuffle_probe();
      test_same_cycle();
      test_reset_mid_probe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

endmodule
